// File: rtl/instruction_decode_pipelined_if.sv
// Decode-stage bundle: fetch-side instruction/control handshake, writeback port,
// ID/EX outputs with execute-side handshake, and the debug register-file view.
interface instruction_decode_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [25:0]                          instruction;
  logic                                 reg_dst;
  logic                                 alu_src;
  logic                                 reg_write;
  logic                                 mem_read;
  logic                                 mem_write;
  logic                                 zero_ext;
  logic                                 flush;
  logic                                 wb_enable;
  logic [4:0]                           wb_address;
  logic [DATA_WIDTH-1:0]                wb_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH-1:0]                alu_input0;
  logic [DATA_WIDTH-1:0]                alu_input1;
  logic [DATA_WIDTH-1:0]                memory_write_data;
  logic [DATA_WIDTH-1:0]                branch;
  logic [5:0]                           func;
  logic [4:0]                           write_register;
  logic                                 out_reg_write;
  logic                                 out_mem_read;
  logic                                 out_mem_write;
  logic                                 hazard_stall;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  io_registers;

  modport master (
    output in_valid, instruction, reg_dst, alu_src, reg_write, mem_read, mem_write,
           zero_ext, flush, wb_enable, wb_address, wb_data, out_ready,
    input  in_ready, out_valid, alu_input0, alu_input1, memory_write_data, branch, func,
           write_register, out_reg_write, out_mem_read, out_mem_write, hazard_stall,
           io_registers
  );

  modport slave (
    input  in_valid, instruction, reg_dst, alu_src, reg_write, mem_read, mem_write,
           zero_ext, flush, wb_enable, wb_address, wb_data, out_ready,
    output in_ready, out_valid, alu_input0, alu_input1, memory_write_data, branch, func,
           write_register, out_reg_write, out_mem_read, out_mem_write, hazard_stall,
           io_registers
  );
endinterface

// File: rtl/instruction_decode_pipelined.sv
// Decode stage: register file with optional write-through bypass, imm extension, load-use stall, ID/EX register.
// Latency 1 cycle; ID/EX holds stable and inReady drops on backpressure, load-use stall or flush.
module instruction_decode_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic                          clk,
  input logic                          rst_n,
  instruction_decode_pipelined_if.slave bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef logic [DATA_WIDTH-1:0]               word_t;
  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regfile_t;

  regfile_t regs_q, regs_d;

  logic       out_valid_q, out_valid_d;
  word_t      alu_input0_q, alu_input0_d;
  word_t      alu_input1_q, alu_input1_d;
  word_t      mem_wdata_q, mem_wdata_d;
  word_t      branch_q, branch_d;
  logic [5:0] func_q, func_d;
  logic [4:0] write_register_q, write_register_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;

  logic [AW-1:0] rs_idx, rt_idx, wb_idx, wr_idx;
  word_t         imm_ext, rs_val, rt_val;
  logic [4:0]    dest_reg;
  logic          hazard, accept, in_ready;

  // Register 0 is hard-wired when ZERO_REG is set, which also blocks bypass from a write to it.
  function automatic word_t read_port(input logic [AW-1:0] addr, input regfile_t arr,
                                      input logic we, input logic [AW-1:0] waddr,
                                      input word_t wdata);
    if (ZERO_REG != 0 && addr == '0) return '0;
    if (BYPASS != 0 && we && waddr == addr) return wdata;
    return arr[addr];
  endfunction

  assign rs_idx = bus.instruction[21 +: AW];
  assign rt_idx = bus.instruction[16 +: AW];
  assign wb_idx = bus.wb_address[AW-1:0];
  assign wr_idx = write_register_q[AW-1:0];

  assign imm_ext  = {{(DATA_WIDTH-16){bus.instruction[15] & ~bus.zero_ext}}, bus.instruction[15:0]};
  assign rs_val   = read_port(rs_idx, regs_q, bus.wb_enable, wb_idx, bus.wb_data);
  assign rt_val   = read_port(rt_idx, regs_q, bus.wb_enable, wb_idx, bus.wb_data);
  assign dest_reg = bus.reg_dst ? bus.instruction[15:11] : bus.instruction[20:16];

  // rt only matters as a source when it feeds the ALU or is the store data.
  assign hazard = bus.in_valid && out_valid_q && mem_read_q && reg_write_q && (wr_idx != '0) &&
                  ((wr_idx == rs_idx) ||
                   ((wr_idx == rt_idx) && (!bus.alu_src || bus.mem_write)));

  assign in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d      = out_valid_q;
    alu_input0_d     = alu_input0_q;
    alu_input1_d     = alu_input1_q;
    mem_wdata_d      = mem_wdata_q;
    branch_d         = branch_q;
    func_d           = func_q;
    write_register_d = write_register_q;
    reg_write_d      = reg_write_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d      = 1'b1;
      alu_input0_d     = rs_val;
      alu_input1_d     = bus.alu_src ? imm_ext : rt_val;
      mem_wdata_d      = rt_val;
      branch_d         = imm_ext;
      func_d           = bus.instruction[5:0];
      write_register_d = dest_reg;
      reg_write_d      = bus.reg_write;
      mem_read_d       = bus.mem_read;
      mem_write_d      = bus.mem_write;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_enable && !(ZERO_REG != 0 && wb_idx == '0)) begin
      regs_d[wb_idx] = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q           <= '0;
      out_valid_q      <= 1'b0;
      alu_input0_q     <= '0;
      alu_input1_q     <= '0;
      mem_wdata_q      <= '0;
      branch_q         <= '0;
      func_q           <= '0;
      write_register_q <= '0;
      reg_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      regs_q           <= regs_d;
      out_valid_q      <= out_valid_d;
      alu_input0_q     <= alu_input0_d;
      alu_input1_q     <= alu_input1_d;
      mem_wdata_q      <= mem_wdata_d;
      branch_q         <= branch_d;
      func_q           <= func_d;
      write_register_q <= write_register_d;
      reg_write_q      <= reg_write_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.hazard_stall      = hazard;
  assign bus.out_valid         = out_valid_q;
  assign bus.alu_input0        = alu_input0_q;
  assign bus.alu_input1        = alu_input1_q;
  assign bus.memory_write_data = mem_wdata_q;
  assign bus.branch            = branch_q;
  assign bus.func              = func_q;
  assign bus.write_register    = write_register_q;
  assign bus.out_reg_write     = reg_write_q;
  assign bus.out_mem_read      = mem_read_q;
  assign bus.out_mem_write     = mem_write_q;
  assign bus.io_registers      = regs_q;

endmodule

// File: tb/tb_instruction_decode_pipelined.sv
// Bench for the decode stage: instance A (32 regs, bypass) and instance B (8 regs, no bypass)
// share one stimulus stream; a transaction-level model predicts both.
module tb_instruction_decode_pipelined;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, reg_dst = 0, alu_src = 0, reg_write = 0, mem_read = 0, mem_write = 0;
  logic        zero_ext = 0, flush = 0, wb_enable = 0, out_ready = 0;
  logic [25:0] instruction = '0;
  logic [4:0]  wb_address = '0;
  logic [31:0] wb_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_decode_pipelined_if #(.DATA_WIDTH(32), .NUM_REGS(32)) ifa ();
  instruction_decode_pipelined_if #(.DATA_WIDTH(32), .NUM_REGS(8))  ifb ();

  assign ifa.in_valid = in_valid;   assign ifb.in_valid = in_valid;
  assign ifa.instruction = instruction; assign ifb.instruction = instruction;
  assign ifa.reg_dst = reg_dst;     assign ifb.reg_dst = reg_dst;
  assign ifa.alu_src = alu_src;     assign ifb.alu_src = alu_src;
  assign ifa.reg_write = reg_write; assign ifb.reg_write = reg_write;
  assign ifa.mem_read = mem_read;   assign ifb.mem_read = mem_read;
  assign ifa.mem_write = mem_write; assign ifb.mem_write = mem_write;
  assign ifa.zero_ext = zero_ext;   assign ifb.zero_ext = zero_ext;
  assign ifa.flush = flush;         assign ifb.flush = flush;
  assign ifa.wb_enable = wb_enable; assign ifb.wb_enable = wb_enable;
  assign ifa.wb_address = wb_address; assign ifb.wb_address = wb_address;
  assign ifa.wb_data = wb_data;     assign ifb.wb_data = wb_data;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  instruction_decode_pipelined #(.DATA_WIDTH(32), .NUM_REGS(32), .BYPASS(1), .ZERO_REG(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  instruction_decode_pipelined #(.DATA_WIDTH(32), .NUM_REGS(8), .BYPASS(0), .ZERO_REG(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct packed {
    logic ov; logic [31:0] a0, a1, mwd, br; logic [5:0] fn; logic [4:0] wr; logic rw, mr, mw;
  } idex_t;

  idex_t       m_id   [2];
  logic [31:0] m_regs [2][32];

  function automatic int nr(int k);  return (k == 0) ? 32 : 8; endfunction
  function automatic int idx(int k, logic [4:0] a); return int'(a) % nr(k); endfunction

  function automatic logic [31:0] m_read(int k, logic [4:0] a);
    int i = idx(k, a);
    if (i == 0) return 32'h0;
    if (k == 0 && wb_enable && idx(k, wb_address) == i) return wb_data;
    return m_regs[k][i];
  endfunction

  function automatic logic m_hazard(int k);
    int w = idx(k, m_id[k].wr);
    return in_valid && m_id[k].ov && m_id[k].mr && m_id[k].rw && (w != 0) &&
           ((w == idx(k, instruction[25:21])) ||
            ((w == idx(k, instruction[20:16])) && (!alu_src || mem_write)));
  endfunction

  function automatic logic m_ready(int k);
    return !flush && !m_hazard(k) && (!m_id[k].ov || out_ready);
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_id[k] = '0;
      for (int i = 0; i < 32; i++) m_regs[k][i] = 32'h0;
    end
  endfunction

  function automatic void m_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ext, rsv, rtv;
      logic rdy;
      ext = zero_ext ? {16'h0, instruction[15:0]} : {{16{instruction[15]}}, instruction[15:0]};
      rsv = m_read(k, instruction[25:21]);
      rtv = m_read(k, instruction[20:16]);
      rdy = m_ready(k);
      if (flush) m_id[k].ov = 1'b0;
      else if (in_valid && rdy) begin
        m_id[k].ov  = 1'b1;
        m_id[k].a0  = rsv;
        m_id[k].a1  = alu_src ? ext : rtv;
        m_id[k].mwd = rtv;
        m_id[k].br  = ext;
        m_id[k].fn  = instruction[5:0];
        m_id[k].wr  = reg_dst ? instruction[15:11] : instruction[20:16];
        m_id[k].rw  = reg_write;
        m_id[k].mr  = mem_read;
        m_id[k].mw  = mem_write;
      end else if (out_ready) m_id[k].ov = 1'b0;
      if (wb_enable && idx(k, wb_address) != 0) m_regs[k][idx(k, wb_address)] = wb_data;
    end
  endfunction

  function automatic idex_t dut_idex(int k);
    idex_t r;
    if (k == 0) r = {ifa.out_valid, ifa.alu_input0, ifa.alu_input1, ifa.memory_write_data, ifa.branch,
                     ifa.func, ifa.write_register, ifa.out_reg_write, ifa.out_mem_read, ifa.out_mem_write};
    else        r = {ifb.out_valid, ifb.alu_input0, ifb.alu_input1, ifb.memory_write_data, ifb.branch,
                     ifb.func, ifb.write_register, ifb.out_reg_write, ifb.out_mem_read, ifb.out_mem_write};
    return r;
  endfunction

  function automatic logic [31:0] dut_reg(int k, int i);
    return (k == 0) ? ifa.io_registers[i] : ifb.io_registers[i % 8];
  endfunction

  task automatic idle_inputs();
    in_valid = 0; reg_dst = 0; alu_src = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    zero_ext = 0; flush = 0; wb_enable = 0; wb_address = '0; wb_data = '0; instruction = '0;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic clock_edge();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    to_negedge();
    clock_edge();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b/%b want 0/0", ifa.out_valid, ifb.out_valid);
    end
    n_checks++;
    if (ifa.io_registers !== '0 || ifb.io_registers !== '0 || ifa.alu_input0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: a0=%h regs nonzero", ifa.alu_input0);
    end
    m_reset();
    rst_n = 1;
    out_ready = 1;
  endtask

  task automatic test_bypass();
    idle_inputs();
    wb_enable = 1; wb_address = 5'd5; wb_data = 32'hDEADBEEF;
    in_valid = 1; instruction = {5'd5, 5'd0, 16'h0000};
    cycle();
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.alu_input0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_on: got ov=%b a0=%h want 1 deadbeef", ifa.out_valid, ifa.alu_input0);
    end
    n_checks++;
    if (ifb.alu_input0 !== 32'h0) begin
      n_fail++; $display("FAIL bypass_off: got a0=%h want 00000000", ifb.alu_input0);
    end
    n_checks++;
    if (ifa.io_registers[5] !== 32'hDEADBEEF || ifb.io_registers[5] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_write: got %h/%h want deadbeef", ifa.io_registers[5], ifb.io_registers[5]);
    end
    wb_enable = 0;
    cycle();
    n_checks++;
    if (ifb.alu_input0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL array_read: got a0=%h want deadbeef", ifb.alu_input0);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    wb_enable = 1; wb_address = 5'd0; wb_data = 32'h1234;
    in_valid = 1; instruction = {5'd0, 5'd0, 16'h0000};
    cycle();
    n_checks++;
    if (ifa.alu_input0 !== 32'h0) begin
      n_fail++; $display("FAIL zero_bypass: got a0=%h want 0", ifa.alu_input0);
    end
    in_valid = 0;
    wb_address = 5'd8;  wb_data = 32'h55550008; cycle();
    wb_address = 5'd13; wb_data = 32'h00000D0D; cycle();
    wb_enable = 0; in_valid = 1; instruction = {5'd0, 5'd8, 16'h0000};
    cycle();
    n_checks++;
    if (ifa.alu_input0 !== 32'h0 || ifb.alu_input0 !== 32'h0 || ifa.io_registers[0] !== 32'h0 ||
        ifb.io_registers[0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_read: got a0=%h/%h want 0/0", ifa.alu_input0, ifb.alu_input0);
    end
    n_checks++;
    if (ifa.memory_write_data !== 32'h55550008 || ifb.memory_write_data !== 32'h0) begin
      n_fail++; $display("FAIL high_addr_bits: got mwd=%h/%h want 55550008/00000000",
                         ifa.memory_write_data, ifb.memory_write_data);
    end
    n_checks++;
    if (ifb.io_registers[5] !== 32'h00000D0D || ifa.io_registers[13] !== 32'h00000D0D) begin
      n_fail++; $display("FAIL alias_write: got %h/%h want 00000d0d", ifb.io_registers[5], ifa.io_registers[13]);
    end
  endtask

  task automatic test_extension();
    idle_inputs();
    in_valid = 1; alu_src = 1; zero_ext = 0; instruction = {5'd0, 5'd0, 16'h8001};
    cycle();
    n_checks++;
    if (ifa.alu_input1 !== 32'hFFFF8001 || ifa.branch !== 32'hFFFF8001 || ifa.func !== 6'h01) begin
      n_fail++; $display("FAIL sign_ext: got a1=%h br=%h fn=%h want ffff8001", ifa.alu_input1, ifa.branch, ifa.func);
    end
    zero_ext = 1;
    cycle();
    n_checks++;
    if (ifa.alu_input1 !== 32'h00008001 || ifb.branch !== 32'h00008001) begin
      n_fail++; $display("FAIL zero_ext: got a1=%h br=%h want 00008001", ifa.alu_input1, ifb.branch);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    in_valid = 1; alu_src = 1; reg_write = 1; mem_read = 1; instruction = {5'd1, 5'd8, 16'h0004};
    cycle();
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.write_register !== 5'd8 || ifa.out_mem_read !== 1'b1) begin
      n_fail++; $display("FAIL load_capture: got ov=%b wr=%0d mr=%b want 1 8 1",
                         ifa.out_valid, ifa.write_register, ifa.out_mem_read);
    end
    alu_src = 0; mem_read = 0; reg_dst = 1; instruction = {5'd8, 5'd2, 5'd3, 5'd0, 6'h20};
    to_negedge();
    n_checks++;
    if (ifa.hazard_stall !== 1'b1 || ifa.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_assert: got stall=%b rdy=%b want 1 0", ifa.hazard_stall, ifa.in_ready);
    end
    n_checks++;
    if (ifb.hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_alias_r0: got stall=%b want 0", ifb.hazard_stall);
    end
    clock_edge();
    n_checks++;
    if (ifa.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bubble: got ov=%b want 0", ifa.out_valid);
    end
    to_negedge();
    n_checks++;
    if (ifa.hazard_stall !== 1'b0 || ifa.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got stall=%b rdy=%b want 0 1", ifa.hazard_stall, ifa.in_ready);
    end
    clock_edge();
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.alu_input0 !== 32'h55550008 || ifa.write_register !== 5'd3) begin
      n_fail++; $display("FAIL add_accept: got ov=%b a0=%h wr=%0d want 1 55550008 3",
                         ifa.out_valid, ifa.alu_input0, ifa.write_register);
    end
  endtask

  task automatic test_backpressure_flush();
    idle_inputs();
    in_valid = 1; alu_src = 1; reg_write = 1; instruction = {5'd13, 5'd0, 16'h0042};
    cycle();
    out_ready = 0; alu_src = 0; instruction = {5'd8, 5'd5, 16'h0000};
    for (int c = 0; c < 3; c++) begin
      to_negedge();
      n_checks++;
      if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready c%0d: got %b/%b want 0", c, ifa.in_ready, ifb.in_ready);
      end
      clock_edge();
      n_checks++;
      if (ifa.out_valid !== 1'b1 || ifa.alu_input0 !== 32'h00000D0D || ifa.alu_input1 !== 32'h42 ||
          ifb.alu_input0 !== 32'h00000D0D) begin
        n_fail++; $display("FAIL bp_stable c%0d: got ov=%b a0=%h a1=%h", c, ifa.out_valid, ifa.alu_input0, ifa.alu_input1);
      end
    end
    flush = 1;
    to_negedge();
    n_checks++;
    if (ifa.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got %b want 0", ifa.in_ready);
    end
    clock_edge();
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0 || ifa.alu_input0 !== 32'h00000D0D) begin
      n_fail++; $display("FAIL flush: got ov=%b/%b a0=%h want 0/0 00000d0d", ifa.out_valid, ifb.out_valid, ifa.alu_input0);
    end
    idle_inputs();
    out_ready = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 15) == 0);
      instruction = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                     11'($urandom)};
      reg_dst = 1'($urandom); alu_src = 1'($urandom); zero_ext = 1'($urandom);
      reg_write = 1'($urandom); mem_read = ($urandom_range(0, 2) == 0); mem_write = ($urandom_range(0, 3) == 0);
      wb_enable = 1'($urandom); wb_address = 5'($urandom); wb_data = $urandom;
      to_negedge();
      n_checks++;
      if (ifa.hazard_stall !== m_hazard(0) || ifa.in_ready !== m_ready(0) ||
          ifb.hazard_stall !== m_hazard(1) || ifb.in_ready !== m_ready(1)) begin
        n_fail++; $display("FAIL rnd_comb c%0d: stall=%b/%b rdy=%b/%b want %b/%b %b/%b", c,
                           ifa.hazard_stall, ifb.hazard_stall, ifa.in_ready, ifb.in_ready,
                           m_hazard(0), m_hazard(1), m_ready(0), m_ready(1));
      end
      clock_edge();
      for (int k = 0; k < 2; k++) begin
        int bad_reg = -1;
        n_checks++;
        if (dut_idex(k) !== m_id[k]) begin
          n_fail++; $display("FAIL rnd_idex%0d c%0d: got %h want %h", k, c, dut_idex(k), m_id[k]);
        end
        for (int i = 0; i < nr(k); i++) if (dut_reg(k, i) !== m_regs[k][i]) bad_reg = i;
        n_checks++;
        if (bad_reg >= 0) begin
          n_fail++; $display("FAIL rnd_reg%0d c%0d: r%0d got %h want %h", k, c, bad_reg,
                             dut_reg(k, bad_reg), m_regs[k][bad_reg]);
        end
      end
    end
    idle_inputs();
    out_ready = 1;
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    wb_enable = 1; wb_address = 5'd5; wb_data = 32'hA5A5A5A5;
    in_valid = 1; instruction = {5'd5, 5'd0, 16'h7777};
    cycle();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifa.alu_input0 !== 32'h0 || ifa.branch !== 32'h0 ||
        ifb.out_valid !== 1'b0 || ifb.branch !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got ov=%b a0=%h br=%h want 0", ifa.out_valid, ifa.alu_input0, ifa.branch);
    end
    n_checks++;
    if (ifa.io_registers !== '0 || ifb.io_registers !== '0) begin
      n_fail++; $display("FAIL async_reset_rf: got r5=%h/%h want 0", ifa.io_registers[5], ifb.io_registers[5]);
    end
    m_reset();
    idle_inputs();
    #1;
    rst_n = 1;
    in_valid = 1; instruction = {5'd5, 5'd0, 16'h0000};
    cycle();
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.alu_input0 !== 32'h0 || ifb.alu_input0 !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_read: got ov=%b a0=%h/%h want 1 0/0", ifa.out_valid,
                         ifa.alu_input0, ifb.alu_input0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_extension();
    test_load_use();
    test_backpressure_flush();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
